// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, FSM
// encoding and default constants for the interrupt controller.
package cp0_pkg;

   localparam int unsigned IP_W  = 6;
   localparam int unsigned EPC_W = 30;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   localparam int unsigned IM_LO   = 10;
   localparam int unsigned IM_HI   = 15;
   localparam int unsigned EXL_BIT = 1;
   localparam int unsigned IE_BIT  = 0;

   localparam logic [31:0] PRID_DEFAULT          = 32'h0000_0001;
   localparam logic [31:0] HANDLER_ENTRY_DEFAULT = 32'h0000_4180;

   typedef enum logic {
      RUN     = 1'b0,
      HANDLER = 1'b1
   } state_t;

endpackage

// File: rtl/cp0_intc_if.sv
// Pipeline-side CP0 bus: device requests, mfc0/mtc0 access, eret and redirect.
interface cp0_intc_if;
   logic [5:0]  HWInt;
   logic [4:0]  addr;
   logic        we;
   logic [31:0] Din;
   logic [29:0] PC;
   logic        EXLClr;
   logic [31:0] Dout;
   logic        IntReq;
   logic [29:0] EPC;
   logic [31:0] VecPC;

   modport master (
      output HWInt, addr, we, Din, PC, EXLClr,
      input  Dout, IntReq, EPC, VecPC
   );

   modport slave (
      input  HWInt, addr, we, Din, PC, EXLClr,
      output Dout, IntReq, EPC, VecPC
   );
endinterface

// File: rtl/cp0_count_cmp.sv
// Count/Compare timer: free-running Count, sticky TI on Count==Compare,
// TI stays clear until Compare has been written once.
module cp0_count_cmp
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [4:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic armed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
         armed   <= 1'b0;
      end else begin
         if (wr_en && addr == REG_COUNT) count <= din;
         else                            count <= count + 32'd1;
         // A Compare write re-arms and acknowledges the timer interrupt
         if (wr_en && addr == REG_COMPARE) begin
            compare <= din;
            armed   <= 1'b1;
            ti      <= 1'b0;
         end else if (armed && count == compare) begin
            ti <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt controller top: SR/Cause/EPC/PRId and interrupt entry FSM.
// Optional Count/Compare timer is built when CP0_COUNT_EN is defined.
module cp0_intc
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID          = PRID_DEFAULT,
   parameter logic [31:0] HANDLER_ENTRY = HANDLER_ENTRY_DEFAULT
) (
   input logic        clk,
   input logic        reset,
   cp0_intc_if.slave  bus
);

   state_t             state_q;
   logic [IP_W-1:0]    im_q;
   logic               ie_q;
   logic [IP_W-1:0]    ip_q;
   logic [EPC_W-1:0]   epc_q;
   logic [IP_W-1:0]    hw_eff;
   logic               int_req_c;
   logic               exl;

   // EXL is the FSM state itself, so the two can never disagree
   assign exl       = (state_q == HANDLER);
   assign int_req_c = (|(ip_q & im_q)) & ie_q & (state_q == RUN);

`ifdef CP0_COUNT_EN
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   cp0_count_cmp u_count_cmp (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.we & ~int_req_c),
      .addr    (bus.addr),
      .din     (bus.Din),
      .count   (count),
      .compare (compare),
      .ti      (ti)
   );

   assign hw_eff = bus.HWInt | {ti, 5'b0_0000};
`else
   assign hw_eff = bus.HWInt;
`endif

   // Interrupt entry wins over any mtc0 in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         im_q    <= '0;
         ie_q    <= 1'b0;
         ip_q    <= '0;
         epc_q   <= '0;
      end else begin
         ip_q <= hw_eff;
         if (int_req_c) begin
            state_q <= HANDLER;
            epc_q   <= bus.PC;
         end else begin
            if (bus.we && bus.addr == REG_SR) begin
               im_q    <= bus.Din[IM_HI:IM_LO];
               ie_q    <= bus.Din[IE_BIT];
               state_q <= state_t'(bus.Din[EXL_BIT]);
            end
            if (bus.we && bus.addr == REG_EPC) epc_q <= bus.Din[31:2];
            // eret overrides the EXL bit of a coincident SR write
            if (bus.EXLClr) state_q <= RUN;
         end
      end
   end

   always_comb begin
      bus.Dout = '0;
      case (bus.addr)
         REG_SR:    bus.Dout = (32'(im_q) << IM_LO) | (32'(exl) << EXL_BIT)
                             | (32'(ie_q) << IE_BIT);
         REG_CAUSE: bus.Dout = 32'(ip_q) << IM_LO;
         REG_EPC:   bus.Dout = {epc_q, 2'b00};
         REG_PRID:  bus.Dout = PRID;
`ifdef CP0_COUNT_EN
         REG_COUNT:   bus.Dout = count;
         REG_COMPARE: bus.Dout = compare;
`endif
         default:   bus.Dout = '0;
      endcase
   end

   assign bus.IntReq = int_req_c;
   assign bus.EPC    = epc_q;
   assign bus.VecPC  = HANDLER_ENTRY;

endmodule
